// File: rtl/mem_turn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_game_pkg
// Purpose  : Shared types, state encodings and width helpers for the memory
//            (pairs) game turn controller and its winner evaluator.
// Contents : state_t + state constants, pw_of()/sw_of() width helpers,
//            params_legal() elaboration-time parameter check.
// Revision : 1.0 - initial release
// ============================================================================
package mem_game_pkg;

  // Turn FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t c_PICK1   = 2'd0;
  localparam state_t c_PICK2   = 2'd1;
  localparam state_t c_RESOLVE = 2'd2;
  localparam state_t c_DONE    = 2'd3;

  // Width of a player index; never narrower than one bit.
  function automatic int pw_of(input int num_players);
    return (num_players < 2) ? 1 : $clog2(num_players);
  endfunction

  // Width of one score field; must be able to hold NUM_PAIRS.
  function automatic int sw_of(input int num_pairs);
    return (num_pairs < 1) ? 1 : $clog2(num_pairs + 1);
  endfunction

  // Legal configuration: 2..8 players, at least one pair, and the card
  // index wide enough to address every card on the board.
  function automatic bit params_legal(input int num_players, input int num_pairs,
                                      input int idx_w);
    return (num_players >= 2) && (num_players <= 8) && (num_pairs >= 1) &&
           ((2 ** idx_w) >= (2 * num_pairs));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_turn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_turn_ctrl_if
// Purpose  : Bundle between the card selector / display logic and the turn
//            controller.
// Ports    : master - selector side: drives select, card_idx, card_sym,
//                     card_avail; observes turn/score/game status.
//            slave  - controller side (mem_turn_ctrl).
// Options  : MEM_TURN_TIMEOUT_EN adds the 'timeout' pulse signal.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_turn_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  parameter int SYM_W       = 4,
  parameter int IDX_W       = 4
);
  import mem_game_pkg::*;

  localparam int PW = pw_of(NUM_PLAYERS);
  localparam int SW = sw_of(NUM_PAIRS);

  logic                      select;
  logic [IDX_W-1:0]          card_idx;
  logic [SYM_W-1:0]          card_sym;
  logic                      card_avail;

  logic [PW-1:0]             player;
  logic [IDX_W-1:0]          first_idx;
  logic [IDX_W-1:0]          second_idx;
  logic [1:0]                pick_cnt;
  logic                      turn_done;
  logic                      match;
  logic                      remove_req;
  logic [NUM_PLAYERS*SW-1:0] scores;
  logic                      game_over;
  logic [PW-1:0]             winner;
  logic                      tie;
`ifdef MEM_TURN_TIMEOUT_EN
  logic                      timeout;
`endif

  modport master (
    output select, card_idx, card_sym, card_avail,
    input  player, first_idx, second_idx, pick_cnt, turn_done, match,
           remove_req, scores, game_over, winner, tie
`ifdef MEM_TURN_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  select, card_idx, card_sym, card_avail,
    output player, first_idx, second_idx, pick_cnt, turn_done, match,
           remove_req, scores, game_over, winner, tie
`ifdef MEM_TURN_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface
`default_nettype wire

// File: rtl/mem_turn_winner.sv
`default_nettype none
// ============================================================================
// Module   : mem_turn_winner
// Purpose  : Combinational argmax over packed per-player scores. Reports the
//            lowest-indexed top scorer and flags a shared top score.
// Ports    : i_scores  - packed scores, player 0 in the LSBs
//            o_winner  - index of the (lowest-indexed) highest scorer
//            o_tie     - two or more players share the top score
// Revision : 1.0 - initial release
// ============================================================================
module mem_turn_winner
  import mem_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  localparam int PW = pw_of(NUM_PLAYERS),
  localparam int SW = sw_of(NUM_PAIRS)
) (
  input  wire logic [NUM_PLAYERS*SW-1:0] i_scores,
  output logic      [PW-1:0]             o_winner,
  output logic                           o_tie
);

  logic [SW-1:0] w_best;
  logic [SW-1:0] w_cur;

  // Strictly-greater replaces the leader, so ties keep the lower index.
  // A later strictly-higher score clears any tie seen so far.
  always_comb begin
    w_best   = i_scores[SW-1:0];
    w_cur    = '0;
    o_winner = '0;
    o_tie    = 1'b0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      w_cur = i_scores[p*SW +: SW];
      if (w_cur > w_best) begin
        w_best   = w_cur;
        o_winner = PW'(p);
        o_tie    = 1'b0;
      end else if (w_cur == w_best) begin
        o_tie = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_turn_ctrl
// Purpose  : Turn and score controller for the N-player memory game. Takes
//            two card picks per turn, compares symbols, scores matches,
//            rotates the turn on a miss and reports the winner at game end.
// Ports    : clk - rising-edge clock
//            rst - asynchronous, active-low reset
//            bus - mem_turn_ctrl_if.slave (picks in, turn/score status out)
// Options  : MEM_TURN_TIMEOUT_EN - forfeit a turn after TIMEOUT_CYC idle
//            cycles in PICK1/PICK2 and pulse bus.timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_turn_ctrl
  import mem_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  parameter int SYM_W       = 4,
  parameter int IDX_W       = 4
`ifdef MEM_TURN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2 ** 24
`endif
) (
  input wire logic        clk,
  input wire logic        rst,
  mem_turn_ctrl_if.slave  bus
);

  localparam int PW = pw_of(NUM_PLAYERS);
  localparam int SW = sw_of(NUM_PAIRS);

  if (!params_legal(NUM_PLAYERS, NUM_PAIRS, IDX_W)) begin : g_param_check
    $error("mem_turn_ctrl: illegal NUM_PLAYERS/NUM_PAIRS/IDX_W combination");
  end

  state_t                    r_state;
  logic [PW-1:0]             r_player;
  logic [IDX_W-1:0]          r_first_idx;
  logic [IDX_W-1:0]          r_second_idx;
  logic [SYM_W-1:0]          r_sym1;
  logic [1:0]                r_pick_cnt;
  logic                      r_turn_done;
  logic                      r_match;
  logic                      r_remove_req;
  logic [NUM_PLAYERS*SW-1:0] r_scores;
  logic [SW-1:0]             r_matched;
  logic                      r_game_over;
  logic [PW-1:0]             r_winner;
  logic                      r_tie;

  logic                      w_accept;
  logic                      w_in_pick;
  logic [PW-1:0]             w_player_next;
  logic [SW-1:0]             w_matched_next;
  logic [NUM_PLAYERS*SW-1:0] w_scores_next;
  logic [PW-1:0]             w_winner;
  logic                      w_tie;

  assign w_in_pick = (r_state == c_PICK1) || (r_state == c_PICK2);

  // A pick counts only for an available card; the second pick must also be
  // a different card from the first.
  assign w_accept = bus.select && bus.card_avail &&
                    ((r_state == c_PICK1) ||
                     ((r_state == c_PICK2) && (bus.card_idx != r_first_idx)));

  assign w_player_next  = (r_player == PW'(NUM_PLAYERS - 1)) ? '0 : r_player + PW'(1);
  assign w_matched_next = r_matched + SW'(1);

  // Current player's score plus one, saturating at NUM_PAIRS.
  always_comb begin
    w_scores_next = r_scores;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if ((PW'(p) == r_player) && (r_scores[p*SW +: SW] < SW'(NUM_PAIRS))) begin
        w_scores_next[p*SW +: SW] = r_scores[p*SW +: SW] + SW'(1);
      end
    end
  end

  // Evaluated on the post-resolve scores so the registered result on entry
  // to DONE already includes the final match.
  mem_turn_winner #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .NUM_PAIRS   (NUM_PAIRS)
  ) u_winner (
    .i_scores (w_scores_next),
    .o_winner (w_winner),
    .o_tie    (w_tie)
  );

`ifdef MEM_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] c_TMAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_timer;
  logic          r_timeout;
  logic          w_expired;

  assign w_expired = w_in_pick && !w_accept && (r_timer == c_TMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (!w_in_pick || w_accept || w_expired) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign bus.timeout = r_timeout;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_PICK1;
      r_player     <= '0;
      r_first_idx  <= '0;
      r_second_idx <= '0;
      r_sym1       <= '0;
      r_pick_cnt   <= 2'd0;
      r_turn_done  <= 1'b0;
      r_match      <= 1'b0;
      r_remove_req <= 1'b0;
      r_scores     <= '0;
      r_matched    <= '0;
      r_game_over  <= 1'b0;
      r_winner     <= '0;
      r_tie        <= 1'b0;
`ifdef MEM_TURN_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_turn_done  <= 1'b0;
      r_remove_req <= 1'b0;
`ifdef MEM_TURN_TIMEOUT_EN
      r_timeout    <= 1'b0;
      if (w_expired) begin
        // Forfeit: abandon the partial turn and pass play on.
        r_state     <= c_PICK1;
        r_pick_cnt  <= 2'd0;
        r_turn_done <= 1'b1;
        r_match     <= 1'b0;
        r_timeout   <= 1'b1;
        r_player    <= w_player_next;
      end else
`endif
      begin
        case (r_state)
          c_PICK1: begin
            if (w_accept) begin
              r_first_idx <= bus.card_idx;
              r_sym1      <= bus.card_sym;
              r_pick_cnt  <= 2'd1;
              r_state     <= c_PICK2;
            end
          end
          c_PICK2: begin
            // The comparison is made as the second card is taken so the
            // result pulses are visible during RESOLVE, one cycle after
            // the select.
            if (w_accept) begin
              r_second_idx <= bus.card_idx;
              r_pick_cnt   <= 2'd2;
              r_match      <= (bus.card_sym == r_sym1);
              r_remove_req <= (bus.card_sym == r_sym1);
              r_turn_done  <= 1'b1;
              r_state      <= c_RESOLVE;
            end
          end
          c_RESOLVE: begin
            r_pick_cnt <= 2'd0;
            if (r_match) begin
              r_scores  <= w_scores_next;
              r_matched <= w_matched_next;
              if (w_matched_next == SW'(NUM_PAIRS)) begin
                r_state     <= c_DONE;
                r_game_over <= 1'b1;
                r_winner    <= w_winner;
                r_tie       <= w_tie;
              end else begin
                r_state <= c_PICK1;
              end
            end else begin
              r_player <= w_player_next;
              r_state  <= c_PICK1;
            end
          end
          default: begin
            // DONE: frozen until reset.
            r_state <= c_DONE;
          end
        endcase
      end
    end
  end

  assign bus.player     = r_player;
  assign bus.first_idx  = r_first_idx;
  assign bus.second_idx = r_second_idx;
  assign bus.pick_cnt   = r_pick_cnt;
  assign bus.turn_done  = r_turn_done;
  assign bus.match      = r_match;
  assign bus.remove_req = r_remove_req;
  assign bus.scores     = r_scores;
  assign bus.game_over  = r_game_over;
  assign bus.winner     = r_winner;
  assign bus.tie        = r_tie;

endmodule
`default_nettype wire
